// File: rtl/best_match_comparator.sv
// ---------------------------------------------------------------------------
// best_match_comparator
//
// Tracks the smallest distance reported by a bank of processing-element
// lanes over a search session. A session opens on CompStart and closes on
// CompLast. On each search cycle the lowest-index ready lane supplies one
// candidate, which is compared against the best distance so far.
//
// Ports
//   clock      : rising-edge clock
//   reset_n    : synchronous active-low reset
//   CompStart  : pulse, opens (or restarts) a session
//   CompLast   : pulse, closes the session after this cycle's candidate
//   PEout      : NUM_PE packed distances, lane i at [i*DIST_W +: DIST_W]
//   PEready    : per-lane distance-valid flags
//   vectorX/Y  : motion vector paired with this cycle's candidate
//   BestDist   : best distance so far (all-ones when nothing accepted)
//   motionX/Y  : vector belonging to BestDist
//   BestPE     : lane that supplied BestDist
//   CandCount  : candidates seen this session, saturating at 255
//   Busy       : session in progress
//   Done       : one-cycle result-valid pulse
//   Found      : at least one candidate accepted this session
//   MultiHit   : sticky, several lanes were ready in the same cycle
// ---------------------------------------------------------------------------
module best_match_comparator #(
    parameter  int NUM_PE   = 16,
    parameter  int DIST_W   = 8,
    parameter  int VEC_W    = 4,
    parameter  int TIE_MODE = 0,
    localparam int PE_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     CompStart,
    input  logic                     CompLast,
    input  logic [NUM_PE*DIST_W-1:0] PEout,
    input  logic [NUM_PE-1:0]        PEready,
    input  logic [VEC_W-1:0]         vectorX,
    input  logic [VEC_W-1:0]         vectorY,
    output logic [DIST_W-1:0]        BestDist,
    output logic [VEC_W-1:0]         motionX,
    output logic [VEC_W-1:0]         motionY,
    output logic [PE_W-1:0]          BestPE,
    output logic [7:0]               CandCount,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Found,
    output logic                     MultiHit
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DIST_W-1:0]   best_dist_q, best_dist_d;
    logic [VEC_W-1:0]    motion_x_q, motion_x_d;
    logic [VEC_W-1:0]    motion_y_q, motion_y_d;
    logic [PE_W-1:0]     best_pe_q, best_pe_d;
    logic [7:0]          cand_count_q, cand_count_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                found_q, found_d;
    logic                multi_hit_q, multi_hit_d;

    logic [PE_W-1:0]     sel_lane;
    logic [DIST_W-1:0]   new_dist;
    logic                any_ready;
    logic                multi_ready;
    logic                accept;

    // Candidate selection: lowest-index ready lane wins. Scanning from the
    // top down lets the last assignment be the lowest set bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sel_lane = '0;
        for (int i = NUM_PE - 1; i >= 0; i--) begin
            if (PEready[i]) begin
                sel_lane = PE_W'(i);
            end
        end
    end

    assign new_dist    = PEout[sel_lane*DIST_W +: DIST_W];
    assign any_ready   = |PEready;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_ready = |(PEready & (PEready - NUM_PE'(1)));
    assign accept      = (TIE_MODE != 0) ? (new_dist <= best_dist_q)
                                         : (new_dist <  best_dist_q);

    always_comb begin
        state_d      = state_q;
        best_dist_d  = best_dist_q;
        motion_x_d   = motion_x_q;
        motion_y_d   = motion_y_q;
        best_pe_d    = best_pe_q;
        cand_count_d = cand_count_q;
        found_d      = found_q;
        multi_hit_d  = multi_hit_q;

        // CompStart is accepted in every state and always wins over CompLast;
        // the vector and lane of the previous result stay visible.
        if (CompStart) begin
            state_d      = SEARCH;
            best_dist_d  = '1;
            cand_count_d = '0;
            found_d      = 1'b0;
            multi_hit_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                SEARCH: begin
                    if (any_ready) begin
                        if (cand_count_q != 8'hFF) begin
                            cand_count_d = cand_count_q + 8'd1;
                        end
                        if (multi_ready) begin
                            multi_hit_d = 1'b1;
                        end
                        if (accept) begin
                            best_dist_d = new_dist;
                            motion_x_d  = vectorX;
                            motion_y_d  = vectorY;
                            best_pe_d   = sel_lane;
                            found_d     = 1'b1;
                        end
                    end
                    if (CompLast) begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Status flags are registered views of the state being entered.
        busy_d = (state_d == SEARCH);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q      <= IDLE;
            best_dist_q  <= '1;
            motion_x_q   <= '0;
            motion_y_q   <= '0;
            best_pe_q    <= '0;
            cand_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            multi_hit_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            best_dist_q  <= best_dist_d;
            motion_x_q   <= motion_x_d;
            motion_y_q   <= motion_y_d;
            best_pe_q    <= best_pe_d;
            cand_count_q <= cand_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            found_q      <= found_d;
            multi_hit_q  <= multi_hit_d;
        end
    end

    assign BestDist  = best_dist_q;
    assign motionX   = motion_x_q;
    assign motionY   = motion_y_q;
    assign BestPE    = best_pe_q;
    assign CandCount = cand_count_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Found     = found_q;
    assign MultiHit  = multi_hit_q;

endmodule

// File: tb/tb_best_match_comparator.sv
// ---------------------------------------------------------------------------
// tb_best_match_comparator
//
// Drives three comparators from one shared session stream:
//   u0 : 16 lanes x 8 bits, earliest tie kept
//   u1 : 16 lanes x 8 bits, latest tie taken
//   u2 :  4 lanes x 12 bits, earliest tie kept
// A session-level model keeps every candidate of the current session and
// derives the expected result by scanning that list; a negedge process
// compares all outputs of all three instances against it every cycle.
// Directed steps add literal expectations at the interesting points.
// ---------------------------------------------------------------------------
module tb_best_match_comparator;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        last = 1'b0;
    logic [15:0] ready16 = '0;
    logic [3:0]  ready4 = '0;
    logic [3:0]  vec_x = '0;
    logic [3:0]  vec_y = '0;
    logic [7:0]  d16 [16];
    logic [11:0] d4 [4];
    logic [127:0] pe_out16;
    logic [47:0]  pe_out4;

    logic [7:0]  best0, best1, cnt0, cnt1, cnt2;
    logic [11:0] best2;
    logic [3:0]  mx0, mx1, mx2, my0, my1, my2, pe0, pe1;
    logic [1:0]  pe2;
    logic        busy0, busy1, busy2, done0, done1, done2;
    logic        found0, found1, found2, multi0, multi1, multi2;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < 16; i++) pe_out16[i*8 +: 8] = d16[i];
        for (int i = 0; i < 4; i++) pe_out4[i*12 +: 12] = d4[i];
    end

    best_match_comparator #(.NUM_PE(16), .DIST_W(8), .VEC_W(4), .TIE_MODE(0)) u0 (
        .clock(clock), .reset_n(reset_n), .CompStart(start), .CompLast(last),
        .PEout(pe_out16), .PEready(ready16), .vectorX(vec_x), .vectorY(vec_y),
        .BestDist(best0), .motionX(mx0), .motionY(my0), .BestPE(pe0),
        .CandCount(cnt0), .Busy(busy0), .Done(done0), .Found(found0), .MultiHit(multi0));

    best_match_comparator #(.NUM_PE(16), .DIST_W(8), .VEC_W(4), .TIE_MODE(1)) u1 (
        .clock(clock), .reset_n(reset_n), .CompStart(start), .CompLast(last),
        .PEout(pe_out16), .PEready(ready16), .vectorX(vec_x), .vectorY(vec_y),
        .BestDist(best1), .motionX(mx1), .motionY(my1), .BestPE(pe1),
        .CandCount(cnt1), .Busy(busy1), .Done(done1), .Found(found1), .MultiHit(multi1));

    best_match_comparator #(.NUM_PE(4), .DIST_W(12), .VEC_W(4), .TIE_MODE(0)) u2 (
        .clock(clock), .reset_n(reset_n), .CompStart(start), .CompLast(last),
        .PEout(pe_out4), .PEready(ready4), .vectorX(vec_x), .vectorY(vec_y),
        .BestDist(best2), .motionX(mx2), .motionY(my2), .BestPE(pe2),
        .CandCount(cnt2), .Busy(busy2), .Done(done2), .Found(found2), .MultiHit(multi2));

    // Output views indexed by instance.
    logic [31:0] o_best [3], o_mx [3], o_my [3], o_pe [3], o_cnt [3];
    logic [31:0] o_busy [3], o_done [3], o_found [3], o_multi [3];

    always_comb begin
        o_best[0] = 32'(best0);  o_best[1] = 32'(best1);  o_best[2] = 32'(best2);
        o_mx[0] = 32'(mx0);      o_mx[1] = 32'(mx1);      o_mx[2] = 32'(mx2);
        o_my[0] = 32'(my0);      o_my[1] = 32'(my1);      o_my[2] = 32'(my2);
        o_pe[0] = 32'(pe0);      o_pe[1] = 32'(pe1);      o_pe[2] = 32'(pe2);
        o_cnt[0] = 32'(cnt0);    o_cnt[1] = 32'(cnt1);    o_cnt[2] = 32'(cnt2);
        o_busy[0] = 32'(busy0);  o_busy[1] = 32'(busy1);  o_busy[2] = 32'(busy2);
        o_done[0] = 32'(done0);  o_done[1] = 32'(done1);  o_done[2] = 32'(done2);
        o_found[0] = 32'(found0); o_found[1] = 32'(found1); o_found[2] = 32'(found2);
        o_multi[0] = 32'(multi0); o_multi[1] = 32'(multi1); o_multi[2] = 32'(multi2);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Session model: phase 0 = idle, 1 = searching, 2 = result cycle.
    // ------------------------------------------------------------------
    typedef struct {
        int d;
        int x;
        int y;
        int lane;
    } cand_t;

    int    all_ones [3] = '{255, 255, 4095};
    int    take_tie [3] = '{0, 1, 0};
    cand_t cands [3][512];
    int    ncand [3];
    int    phase [3];
    int    held_x [3], held_y [3], held_pe [3];
    int    multi_seen [3];
    int    e_best [3], e_mx [3], e_my [3], e_pe [3], e_cnt [3];
    int    e_busy [3], e_done [3], e_found [3], e_multi [3];
    logic [15:0] m_rdy;
    int    m_lane;
    int    m_d;

    always @(posedge clock) begin
        for (int m = 0; m < 3; m++) begin
            m_rdy = (m == 2) ? {12'd0, ready4} : ready16;
            if (!reset_n) begin
                phase[m] = 0;
                ncand[m] = 0;
                held_x[m] = 0;
                held_y[m] = 0;
                held_pe[m] = 0;
                multi_seen[m] = 0;
            end else if (start) begin
                // New session: previous vector/lane remain visible.
                held_x[m] = e_mx[m];
                held_y[m] = e_my[m];
                held_pe[m] = e_pe[m];
                ncand[m] = 0;
                multi_seen[m] = 0;
                phase[m] = 1;
            end else if (phase[m] == 1) begin
                if (m_rdy != 0) begin
                    m_lane = -1;
                    for (int i = 0; i < 16; i++)
                        if (m_rdy[i] && m_lane < 0) m_lane = i;
                    if (m == 2) m_d = int'(d4[m_lane[1:0]]);
                    else        m_d = int'(d16[m_lane[3:0]]);
                    if (ncand[m] < 512) begin
                        cands[m][ncand[m]].d = m_d;
                        cands[m][ncand[m]].x = int'(vec_x);
                        cands[m][ncand[m]].y = int'(vec_y);
                        cands[m][ncand[m]].lane = m_lane;
                        ncand[m]++;
                    end
                    if ($countones(m_rdy) > 1) multi_seen[m] = 1;
                end
                if (last) phase[m] = 2;
            end else if (phase[m] == 2) begin
                phase[m] = 0;
            end

            // Result = scan of the whole session's candidate list.
            e_best[m] = all_ones[m];
            e_mx[m] = held_x[m];
            e_my[m] = held_y[m];
            e_pe[m] = held_pe[m];
            e_found[m] = 0;
            for (int k = 0; k < ncand[m]; k++) begin
                if (take_tie[m] != 0 ? cands[m][k].d <= e_best[m] : cands[m][k].d < e_best[m]) begin
                    e_best[m] = cands[m][k].d;
                    e_mx[m] = cands[m][k].x;
                    e_my[m] = cands[m][k].y;
                    e_pe[m] = cands[m][k].lane;
                    e_found[m] = 1;
                end
            end
            e_cnt[m] = (ncand[m] > 255) ? 255 : ncand[m];
            e_multi[m] = multi_seen[m];
            e_busy[m] = (phase[m] == 1) ? 1 : 0;
            e_done[m] = (phase[m] == 2) ? 1 : 0;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            for (int m = 0; m < 3; m++) begin
                check($sformatf("u%0d.BestDist", m), o_best[m], 32'(e_best[m]));
                check($sformatf("u%0d.motionX", m), o_mx[m], 32'(e_mx[m]));
                check($sformatf("u%0d.motionY", m), o_my[m], 32'(e_my[m]));
                check($sformatf("u%0d.BestPE", m), o_pe[m], 32'(e_pe[m]));
                check($sformatf("u%0d.CandCount", m), o_cnt[m], 32'(e_cnt[m]));
                check($sformatf("u%0d.Busy", m), o_busy[m], 32'(e_busy[m]));
                check($sformatf("u%0d.Done", m), o_done[m], 32'(e_done[m]));
                check($sformatf("u%0d.Found", m), o_found[m], 32'(e_found[m]));
                check($sformatf("u%0d.MultiHit", m), o_multi[m], 32'(e_multi[m]));
            end
        end
    end

    // One clock of stimulus; pulses drop back to zero afterwards.
    task automatic step(input logic s, input logic l, input logic [15:0] r16,
                        input logic [3:0] r4, input logic [3:0] vx, input logic [3:0] vy);
        start = s;
        last = l;
        ready16 = r16;
        ready4 = r4;
        vec_x = vx;
        vec_y = vy;
        @(posedge clock);
        #1;
        start = 1'b0;
        last = 1'b0;
        ready16 = '0;
        ready4 = '0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) d16[i] = 8'h00;
        for (int i = 0; i < 4; i++) d4[i] = 12'h000;

        // Reset state
        step(0, 0, 16'h0, 4'h0, 4'd0, 4'd0);
        chk_en = 1'b1;
        step(0, 0, 16'h0, 4'h0, 4'd0, 4'd0);
        check("rst u0 BestDist", 32'(best0), 32'hFF);
        check("rst u2 BestDist", 32'(best2), 32'hFFF);
        check("rst u0 Busy", 32'(busy0), 32'h0);
        check("rst u0 CandCount", 32'(cnt0), 32'h0);
        reset_n = 1'b1;
        step(0, 0, 16'h0, 4'h0, 4'd0, 4'd0);

        // Basic session: best is lane 1 with 0x20
        step(1, 0, 16'h0, 4'h0, 4'd0, 4'd0);
        check("basic Busy", 32'(busy0), 32'h1);
        d16[0] = 8'h40; step(0, 0, 16'h0001, 4'h0, 4'd3, 4'd5);
        d16[1] = 8'h20; step(0, 0, 16'h0002, 4'h0, 4'd7, 4'd1);
        d16[2] = 8'h30; step(0, 0, 16'h0004, 4'h0, 4'd9, 4'd9);
        step(0, 1, 16'h0, 4'h0, 4'd0, 4'd0);
        check("basic Done", 32'(done0), 32'h1);
        check("basic BestDist", 32'(best0), 32'h20);
        check("basic motionX", 32'(mx0), 32'h7);
        check("basic motionY", 32'(my0), 32'h1);
        check("basic BestPE", 32'(pe0), 32'h1);
        check("basic CandCount", 32'(cnt0), 32'h3);
        check("basic Found", 32'(found0), 32'h1);
        check("basic u2 Found", 32'(found2), 32'h0);
        step(0, 0, 16'h0, 4'h0, 4'd0, 4'd0);
        check("basic Done drops", 32'(done0), 32'h0);
        check("basic held BestDist", 32'(best0), 32'h20);

        // Tie handling, second candidate arrives together with CompLast
        step(1, 0, 16'h0, 4'h0, 4'd0, 4'd0);
        d16[0] = 8'h10; step(0, 0, 16'h0001, 4'h0, 4'd1, 4'd1);
        step(0, 1, 16'h0001, 4'h0, 4'd2, 4'd2);
        check("tie0 motionX", 32'(mx0), 32'h1);
        check("tie1 motionX", 32'(mx1), 32'h2);
        check("tie1 motionY", 32'(my1), 32'h2);
        check("tie Done", 32'(done1), 32'h1);
        step(0, 0, 16'h0, 4'h0, 4'd0, 4'd0);

        // Two lanes ready at once: lowest index wins even though lane 7 is smaller
        step(1, 0, 16'h0, 4'h0, 4'd0, 4'd0);
        d16[4] = 8'h05; d16[7] = 8'h01;
        step(0, 1, 16'h0090, 4'h0, 4'd6, 4'd9);
        check("multi BestDist", 32'(best0), 32'h05);
        check("multi BestPE", 32'(pe0), 32'h4);
        check("multi MultiHit", 32'(multi0), 32'h1);
        check("multi CandCount", 32'(cnt0), 32'h1);
        step(0, 0, 16'h0, 4'h0, 4'd0, 4'd0);

        // Empty session; previous vector stays visible
        step(1, 0, 16'h0, 4'h0, 4'd0, 4'd0);
        check("restart MultiHit clr", 32'(multi0), 32'h0);
        step(0, 1, 16'h0, 4'h0, 4'd0, 4'd0);
        check("empty Done", 32'(done0), 32'h1);
        check("empty BestDist", 32'(best0), 32'hFF);
        check("empty Found", 32'(found0), 32'h0);
        check("empty CandCount", 32'(cnt0), 32'h0);
        check("empty held motionX", 32'(mx0), 32'h6);
        step(0, 0, 16'h0, 4'h0, 4'd0, 4'd0);
        step(0, 1, 16'h0, 4'h0, 4'd0, 4'd0);
        check("idle Last Busy", 32'(busy0), 32'h0);
        check("idle Last Done", 32'(done0), 32'h0);

        // 300 candidates: count saturates
        step(1, 0, 16'h0, 4'h0, 4'd0, 4'd0);
        d16[0] = 8'h80;
        for (int i = 0; i < 300; i++) step(0, 0, 16'h0001, 4'h0, 4'(i % 16), 4'd3);
        step(0, 1, 16'h0, 4'h0, 4'd0, 4'd0);
        check("sat CandCount", 32'(cnt0), 32'hFF);
        check("sat u0 motionX", 32'(mx0), 32'h0);
        check("sat u1 motionX", 32'(mx1), 32'hB);

        // All-ones distance: only the latest-tie instance accepts it
        step(1, 0, 16'h0, 4'h0, 4'd0, 4'd0);
        d16[0] = 8'hFF;
        step(0, 1, 16'h0001, 4'h0, 4'd5, 4'd5);
        check("ones u1 Found", 32'(found1), 32'h1);
        check("ones u1 motionX", 32'(mx1), 32'h5);
        check("ones u0 Found", 32'(found0), 32'h0);

        // CompStart in the result cycle opens a new session
        step(1, 0, 16'h0, 4'h0, 4'd0, 4'd0);
        check("done-start Busy", 32'(busy0), 32'h1);
        check("done-start Done", 32'(done0), 32'h0);
        d4[3] = 12'h800; step(0, 0, 16'h0, 4'h8, 4'd4, 4'd4);
        d4[0] = 12'h7FF; step(0, 0, 16'h0, 4'h1, 4'd8, 4'd2);
        check("wide BestDist", 32'(best2), 32'h7FF);
        check("wide BestPE", 32'(pe2), 32'h0);
        check("wide CandCount", 32'(cnt2), 32'h2);
        step(1, 1, 16'h0, 4'h1, 4'd0, 4'd0);
        check("wide restart BestDist", 32'(best2), 32'hFFF);
        check("wide restart Busy", 32'(busy2), 32'h1);
        check("wide restart Done", 32'(done2), 32'h0);
        step(0, 1, 16'h0, 4'h0, 4'd0, 4'd0);
        step(0, 0, 16'h0, 4'h0, 4'd0, 4'd0);

        // Reset aborts a session
        step(1, 0, 16'h0, 4'h0, 4'd0, 4'd0);
        d16[0] = 8'h08; step(0, 0, 16'h0001, 4'h0, 4'd2, 4'd3);
        check("abort pre BestDist", 32'(best0), 32'h08);
        reset_n = 1'b0;
        step(0, 1, 16'h0001, 4'h0, 4'd0, 4'd0);
        check("abort BestDist", 32'(best0), 32'hFF);
        check("abort motionX", 32'(mx0), 32'h0);
        check("abort BestPE", 32'(pe0), 32'h0);
        check("abort Busy", 32'(busy0), 32'h0);
        check("abort Done", 32'(done0), 32'h0);
        check("abort Found", 32'(found0), 32'h0);
        reset_n = 1'b1;
        step(0, 0, 16'h0, 4'h0, 4'd0, 4'd0);
        check("abort no Done", 32'(done0), 32'h0);
        step(0, 0, 16'h0, 4'h0, 4'd0, 4'd0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
